// File: rtl/digital_clock_pkg.sv
// Shared field widths, limits and the packed time record for the digital clock.
package digital_clock_pkg;

    localparam int SEC_W = 6;
    localparam int MIN_W = 6;
    localparam int HR_W  = 5;

    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
    localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
    localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;

    // Field order matches the set_time bus: {hr, min, sec}.
    typedef struct packed {
        logic [HR_W-1:0]  hr;
        logic [MIN_W-1:0] min;
        logic [SEC_W-1:0] sec;
    } time_t;

    // A load is accepted only if every field is inside its legal range.
    function automatic logic time_valid(input time_t t);
        time_valid = (t.sec <= SEC_MAX) && (t.min <= MIN_MAX) && (t.hr <= HR_MAX);
    endfunction

    // Pad image of a time value; the top pad bit is unused in time mode.
    function automatic logic [17:0] time_to_pads(input time_t t);
        time_to_pads = {1'b0, t.hr, t.min, t.sec};
    endfunction

endpackage

// File: rtl/digital_clock_mod_counter.sv
// Wrapping modulo counter with clear, load and increment; carry flags a wrap.
module mod_counter #(
    parameter int            W   = 6,
    parameter logic [W-1:0]  MAX = {W{1'b1}}
) (
    input  logic         clock,
    input  logic         resetb,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic         carry
);

    logic [W-1:0] r_value;

    // Counter state: reset/clear dominate, then load, then the wrapping increment.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            r_value <= {W{1'b0}};
        end else if (clr) begin
            r_value <= {W{1'b0}};
        end else if (load) begin
            r_value <= load_val;
        end else if (inc) begin
            if (r_value == MAX) begin
                r_value <= {W{1'b0}};
            end else begin
                r_value <= r_value + W'(1);
            end
        end else begin
            r_value <= r_value;
        end
    end

    assign value = r_value;
    // Carry feeds the next stage's increment; clear/load there override it.
    assign carry = inc & (r_value == MAX);

endmodule

// File: rtl/digital_clock.sv
// Binary hh:mm:ss clock with a 1 Hz prescaler, firmware load/clear and pad override.
module digital_clock
    import digital_clock_pkg::*;
#(
    parameter int CLK_DIV = 12_500_000
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic        run_en,
    input  logic        clear,
    input  logic        set_valid,
    input  logic [16:0] set_time,
    input  logic        ovr_en,
    input  logic [17:0] ovr_data,
    output logic        tick_o,
    output logic [17:0] io_out,
    output logic [17:0] io_oeb
);

    localparam int            PW         = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0]    r_presc;
    logic             r_tick;
    logic [17:0]      r_io_out;

    time_t            w_set;
    time_t            w_now;
    logic             w_load;
    logic             w_tick;
    logic             w_sec_carry;
    logic             w_min_carry;
    logic             w_hr_carry_unused;
    logic [SEC_W-1:0] w_sec;
    logic [MIN_W-1:0] w_min;
    logic [HR_W-1:0]  w_hr;

    assign w_set  = time_t'(set_time);
    // An out-of-range load behaves as if set_valid had not been asserted.
    assign w_load = set_valid & time_valid(w_set);
    assign w_tick = run_en & (r_presc == PRESC_LAST);

    // Prescaler: cleared by clear or an accepted load, frozen while run_en is low.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            r_presc <= {PW{1'b0}};
        end else if (clear || w_load) begin
            r_presc <= {PW{1'b0}};
        end else if (run_en) begin
            if (r_presc == PRESC_LAST) begin
                r_presc <= {PW{1'b0}};
            end else begin
                r_presc <= r_presc + PW'(1);
            end
        end else begin
            r_presc <= r_presc;
        end
    end

    mod_counter #(.W(SEC_W), .MAX(SEC_MAX)) u_sec (
        .clock    (clock),
        .resetb   (resetb),
        .clr      (clear),
        .load     (w_load),
        .load_val (w_set.sec),
        .inc      (w_tick),
        .value    (w_sec),
        .carry    (w_sec_carry)
    );

    mod_counter #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
        .clock    (clock),
        .resetb   (resetb),
        .clr      (clear),
        .load     (w_load),
        .load_val (w_set.min),
        .inc      (w_sec_carry),
        .value    (w_min),
        .carry    (w_min_carry)
    );

    mod_counter #(.W(HR_W), .MAX(HR_MAX)) u_hr (
        .clock    (clock),
        .resetb   (resetb),
        .clr      (clear),
        .load     (w_load),
        .load_val (w_set.hr),
        .inc      (w_min_carry),
        .value    (w_hr),
        .carry    (w_hr_carry_unused)
    );

    assign w_now.hr  = w_hr;
    assign w_now.min = w_min;
    assign w_now.sec = w_sec;

    // Tick pulse: a tick swallowed by clear or a load is not reported.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            r_tick <= 1'b0;
        end else if (clear || w_load) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_tick;
        end
    end

    // Pad register: override value or the current time, one cycle behind.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            r_io_out <= 18'h00000;
        end else if (ovr_en) begin
            r_io_out <= ovr_data;
        end else begin
            r_io_out <= time_to_pads(w_now);
        end
    end

    assign tick_o = r_tick;
    assign io_out = r_io_out;
    // Pads are permanently driven, including through reset.
    assign io_oeb = 18'h00000;

endmodule

// File: tb/tb_digital_clock.sv
// Self-checking bench: seconds-of-day reference model feeding a scoreboard queue.
module tb_digital_clock;

    localparam int CLK_DIV = 4;

    logic        clock = 1'b0;
    logic        resetb;
    logic        run_en;
    logic        clear;
    logic        set_valid;
    logic [16:0] set_time;
    logic        ovr_en;
    logic [17:0] ovr_data;
    logic        tick_o;
    logic [17:0] io_out;
    logic [17:0] io_oeb;

    typedef struct packed {
        logic        tick;
        logic [17:0] io;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_tsec  = 0;   // model time as seconds of day
    int   m_presc = 0;

    digital_clock #(.CLK_DIV(CLK_DIV)) dut (
        .clock     (clock),
        .resetb    (resetb),
        .run_en    (run_en),
        .clear     (clear),
        .set_valid (set_valid),
        .set_time  (set_time),
        .ovr_en    (ovr_en),
        .ovr_data  (ovr_data),
        .tick_o    (tick_o),
        .io_out    (io_out),
        .io_oeb    (io_oeb)
    );

    always #5 clock = ~clock;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] pads_of(input int t);
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        h = 5'(t / 3600);
        m = 6'((t / 60) % 60);
        s = 6'(t % 60);
        return {1'b0, h, m, s};
    endfunction

    // Advance the model by one edge, push its prediction, clock the DUT, compare.
    task automatic step();
        exp_t e;
        exp_t got;
        int   h;
        int   m;
        int   s;
        logic tk;
        h = int'(set_time[16:12]);
        m = int'(set_time[11:6]);
        s = int'(set_time[5:0]);
        if (!resetb) begin
            e.io = 18'h0; e.tick = 1'b0; m_tsec = 0; m_presc = 0;
        end else begin
            e.io = ovr_en ? ovr_data : pads_of(m_tsec);
            tk   = run_en && (m_presc == CLK_DIV - 1);
            if (clear) begin
                m_tsec = 0; m_presc = 0; e.tick = 1'b0;
            end else if (set_valid && h <= 23 && m <= 59 && s <= 59) begin
                m_tsec = h * 3600 + m * 60 + s; m_presc = 0; e.tick = 1'b0;
            end else begin
                if (run_en) m_presc = (m_presc + 1) % CLK_DIV;
                if (tk) m_tsec = (m_tsec + 1) % 86400;
                e.tick = tk;
            end
        end
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        got = sb_q.pop_front();
        chk_eq("sb_io", 32'(io_out), 32'(got.io));
        chk_eq("sb_tick", 32'(tick_o), 32'(got.tick));
        chk_eq("io_oeb", 32'(io_oeb), 32'h0);
    endtask

    // Step until tick_o is seen (bounded); returns the number of steps taken.
    task automatic wait_tick(output int cyc);
        cyc = 0;
        while (tick_o !== 1'b1 && cyc < 20) begin
            step();
            cyc++;
        end
        if (tick_o !== 1'b1) chk_eq("tick_timeout", 32'(tick_o), 32'h1);
    endtask

    initial begin
        int          cyc;
        logic [17:0] held;

        resetb = 1'b0; run_en = 1'b0; clear = 1'b0; set_valid = 1'b0;
        set_time = 17'h0; ovr_en = 1'b0; ovr_data = 18'h0;
        repeat (3) step();
        chk_eq("rst_io", 32'(io_out), 32'h0);
        chk_eq("rst_tick", 32'(tick_o), 32'h0);

        // Count from reset: one step every CLK_DIV cycles.
        resetb = 1'b1; run_en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            if (k == 1) begin
                wait_tick(cyc);
            end else begin
                wait_tick(cyc);
                cyc = cyc + 1;   // include the step taken after the previous tick
            end
            chk_eq("tick_gap", 32'(cyc), 32'(CLK_DIV));
            step();
            chk_eq("sec_step", 32'(io_out), 32'(k));
        end

        // Freeze: pads constant, no ticks, prescaler held.
        run_en = 1'b0;
        held = io_out;
        for (int i = 0; i < 20; i++) begin
            step();
            chk_eq("hold_io", 32'(io_out), 32'(held));
            chk_eq("hold_tick", 32'(tick_o), 32'h0);
        end
        run_en = 1'b1;
        wait_tick(cyc);
        chk_eq("resume_gap", 32'(cyc), 32'd3);

        // Seconds carry into minutes.
        run_en = 1'b0; set_valid = 1'b1; set_time = {5'd0, 6'd0, 6'd59};
        step();
        set_valid = 1'b0; run_en = 1'b1;
        wait_tick(cyc);
        step();
        chk_eq("min_carry", 32'(io_out), 32'h00040);

        // Out-of-range load is ignored.
        run_en = 1'b0; set_valid = 1'b1; set_time = {5'd3, 6'd60, 6'd0};
        step();
        set_valid = 1'b0;
        step();
        chk_eq("bad_load", 32'(io_out), 32'h00040);

        // Full day wrap.
        set_valid = 1'b1; set_time = {5'd23, 6'd59, 6'd59};
        step();
        set_valid = 1'b0; run_en = 1'b1;
        step();
        chk_eq("load_2359", 32'(io_out), 32'h17EFB);
        wait_tick(cyc);
        step();
        chk_eq("day_wrap", 32'(io_out), 32'h0);

        // Override then clear with override dropped.
        ovr_en = 1'b1; ovr_data = 18'h000FF;
        step();
        chk_eq("ovr_io", 32'(io_out), 32'h000FF);
        repeat (5) step();
        chk_eq("ovr_hold", 32'(io_out), 32'h000FF);
        clear = 1'b1; ovr_en = 1'b0;
        step();
        clear = 1'b0;
        step();
        chk_eq("clr_io", 32'(io_out), 32'h0);

        // Valid load, then load and clear together: clear wins.
        run_en = 1'b0; set_valid = 1'b1; set_time = {5'd1, 6'd2, 6'd3};
        step();
        set_valid = 1'b0;
        step();
        chk_eq("load_010203", 32'(io_out), 32'h01083);
        set_valid = 1'b1; clear = 1'b1; set_time = {5'd4, 6'd5, 6'd6};
        step();
        set_valid = 1'b0; clear = 1'b0;
        step();
        chk_eq("clr_over_set", 32'(io_out), 32'h0);

        // Reset in the middle of counting.
        run_en = 1'b1;
        repeat (7) step();
        resetb = 1'b0;
        step();
        chk_eq("mid_rst_io", 32'(io_out), 32'h0);
        chk_eq("mid_rst_tick", 32'(tick_o), 32'h0);
        resetb = 1'b1;
        repeat (6) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
